// File: rtl/voice_scheduler.sv
// voice_scheduler -- polyphonic voice allocator and round-robin slot dispatcher.
//
// Holds NBANKS voices (7-bit MIDI note + 4-bit age). Note-on/off commands are
// accepted in IDLE, the table is scanned one voice per cycle, and every table
// write happens on the single COMMIT edge. A free-running slot index dispatches
// one voice per clk_en strobe.
//
// Configuration macro: VOICE_STEAL_EN
//   defined   : a note-on that finds the table full replaces the oldest voice
//   undefined : that note-on is dropped and o_overflow pulses during COMMIT
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   clk_en           dispatch advance strobe
//   i_cmd_valid/o_cmd_ready/i_cmd   command handshake; [15] on/off, [14:8] note
//   o_midi, o_slot, o_frame_start   dispatched voice note, slot index, slot==0 flag
//   o_active_count   registered number of occupied voices
//   o_overflow       note-on rejected for lack of a free voice
module voice_scheduler #(
  parameter int NBANKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd,
  output logic [6:0]  o_midi,
  output logic [3:0]  o_slot,
  output logic        o_frame_start,
  output logic [3:0]  o_active_count,
  output logic        o_overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [3:0] LAST     = 4'(NBANKS - 1);

  logic [1:0] state_q, state_d;
  logic [6:0] note_q [NBANKS];
  logic [6:0] note_d [NBANKS];
  logic [3:0] age_q  [NBANKS];
  logic [3:0] age_d  [NBANKS];

  logic       cmd_on_q, stop_q;
  logic [6:0] cmd_note_q;
  logic [3:0] k_q;
  logic       free_hit_q, match_hit_q;
  logic [3:0] free_idx_q, match_idx_q;
`ifdef VOICE_STEAL_EN
  logic [3:0] old_idx_q, old_age_q;
`endif

  logic [3:0] idx_q, slot_q, count_q, count_d;
  logic [6:0] midi_q;
  logic       frame_q;
  logic       accept, is_stop, ovf, alloc;
  logic [3:0] tgt;
  logic       cmd_unused;

  assign cmd_unused  = ^i_cmd[7:0];
  assign o_cmd_ready = (state_q == S_IDLE) && !reset;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign is_stop     = !i_cmd[15] && (i_cmd[14:8] == 7'h7F);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = is_stop ? S_COMMIT : S_SCAN;
      S_SCAN:   if (k_q == LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command capture and scan bookkeeping; cleared on every acceptance so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_on_q    <= i_cmd[15];
      cmd_note_q  <= i_cmd[14:8];
      stop_q      <= is_stop;
      k_q         <= 4'd0;
      free_hit_q  <= 1'b0;
      match_hit_q <= 1'b0;
    end else if (state_q == S_SCAN) begin
      if (!free_hit_q && note_q[k_q] == 7'd0) begin
        free_hit_q <= 1'b1;
        free_idx_q <= k_q;
      end
      if (!match_hit_q && note_q[k_q] == cmd_note_q) begin
        match_hit_q <= 1'b1;
        match_idx_q <= k_q;
      end
`ifdef VOICE_STEAL_EN
      // Strict compare keeps the lowest index among equal maximum ages.
      if (k_q == 4'd0 || age_q[k_q] > old_age_q) begin
        old_idx_q <= k_q;
        old_age_q <= age_q[k_q];
      end
`endif
      k_q <= k_q + 4'd1;
    end
  end

  // All table writes are decided here and land only while in COMMIT.
  always_comb begin
    ovf   = 1'b0;
    alloc = 1'b0;
    tgt   = 4'd0;
    for (int i = 0; i < NBANKS; i++) begin
      note_d[i] = note_q[i];
      age_d[i]  = age_q[i];
    end
    if (state_q == S_COMMIT) begin
      if (stop_q) begin
        for (int i = 0; i < NBANKS; i++) begin
          note_d[i] = 7'd0;
          age_d[i]  = 4'd0;
        end
      end else if (!cmd_on_q) begin
        for (int i = 0; i < NBANKS; i++)
          if (match_hit_q && 4'(i) == match_idx_q) begin
            note_d[i] = 7'd0;
            age_d[i]  = 4'd0;
          end
      end else if (cmd_note_q != 7'd0) begin
        if (match_hit_q) begin
          for (int i = 0; i < NBANKS; i++)
            if (4'(i) == match_idx_q) age_d[i] = 4'd0;
        end else if (free_hit_q) begin
          alloc = 1'b1;
          tgt   = free_idx_q;
        end else begin
`ifdef VOICE_STEAL_EN
          alloc = 1'b1;
          tgt   = old_idx_q;
`else
          ovf   = 1'b1;
`endif
        end
        if (alloc) begin
          for (int i = 0; i < NBANKS; i++) begin
            if (4'(i) == tgt) begin
              note_d[i] = cmd_note_q;
              age_d[i]  = 4'd0;
            end else if (note_q[i] != 7'd0 && age_q[i] != LAST) begin
              age_d[i] = age_q[i] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBANKS; i++) begin
        note_q[i] <= 7'd0;
        age_q[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NBANKS; i++) begin
        note_q[i] <= note_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  always_comb begin
    count_d = 4'd0;
    for (int i = 0; i < NBANKS; i++)
      count_d = count_d + {3'd0, (note_q[i] != 7'd0)};
  end

  // Dispatch reads the registered table, so a same-edge COMMIT write to the
  // dispatched slot is seen on the next pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 4'd0;
      midi_q  <= 7'd0;
      slot_q  <= 4'd0;
      frame_q <= 1'b0;
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
      if (clk_en) begin
        midi_q  <= note_q[idx_q];
        slot_q  <= idx_q;
        frame_q <= (idx_q == 4'd0);
        idx_q   <= (idx_q == LAST) ? 4'd0 : idx_q + 4'd1;
      end
    end
  end

  assign o_midi         = midi_q;
  assign o_slot         = slot_q;
  assign o_frame_start  = frame_q;
  assign o_active_count = count_q;
  assign o_overflow     = ovf;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_cmd;
  logic [6:0]  o_midi;
  logic [3:0]  o_slot;
  logic        o_frame_start;
  logic [3:0]  o_active_count;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  logic [6:0] snap [16];
  logic [6:0] exp_t [10];
  int frame_bad;
  int low_n, ovf_n;

  voice_scheduler #(.NBANKS(10)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd(i_cmd),
    .o_midi(o_midi), .o_slot(o_slot), .o_frame_start(o_frame_start),
    .o_active_count(o_active_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; i_cmd_valid = 1'b0; clk_en = 1'b0; i_cmd = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  // Issues one command, returns ready-low cycle count and overflow pulses seen,
  // then waits one more cycle so the active count has caught up.
  task automatic send_cmd(input logic [15:0] c, output int low, output int ovf);
    @(negedge clk);
    clk_en = 1'b1; i_cmd = c; i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    low = 0; ovf = 0;
    while (o_cmd_ready !== 1'b1 && low < 50) begin
      if (o_overflow === 1'b1) ovf++;
      low++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic capture_frame();
    clk_en = 1'b1;
    frame_bad = 0;
    for (int i = 0; i < 16; i++) snap[i] = 7'h7F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      snap[o_slot] = o_midi;
      if (o_frame_start !== (o_slot == 4'd0)) frame_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b0; i_cmd_valid = 1'b0; i_cmd = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b want 0", o_cmd_ready); end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", o_cmd_ready); end
    checks++;
    if ({o_midi, o_slot, o_frame_start, o_active_count, o_overflow} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs midi=%h slot=%0d fs=%b cnt=%0d ovf=%b want all 0",
               o_midi, o_slot, o_frame_start, o_active_count, o_overflow);
    end
  endtask

  task automatic test_note_on_basic();
    send_cmd(16'hC500, low_n, ovf_n);
    checks++;
    if (low_n != 11) begin errors++; $display("FAIL basic_ready_low got %0d want 11", low_n); end
    checks++;
    if (o_active_count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d want 1", o_active_count); end
    capture_frame();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snap[i] !== ((i == 0) ? 7'h45 : 7'h00)) begin
        errors++; $display("FAIL basic_slot%0d got %h want %h", i, snap[i], (i == 0) ? 7'h45 : 7'h00);
      end
    end
    checks++;
    if (frame_bad != 0) begin errors++; $display("FAIL basic_frame_start bad=%0d want 0", frame_bad); end
  endtask

  task automatic test_alloc_release();
    do_reset();
    send_cmd(16'hBC00, low_n, ovf_n);
    send_cmd(16'hC000, low_n, ovf_n);
    send_cmd(16'hC300, low_n, ovf_n);
    send_cmd(16'h4000, low_n, ovf_n);
    checks++;
    if (o_active_count !== 4'd2) begin errors++; $display("FAIL alloc_count_after_off got %0d want 2", o_active_count); end
    capture_frame();
    checks++;
    if ({snap[0], snap[1], snap[2]} !== {7'h3C, 7'h00, 7'h43}) begin
      errors++; $display("FAIL alloc_after_off got %h %h %h want 3c 00 43", snap[0], snap[1], snap[2]);
    end
    send_cmd(16'h5500, low_n, ovf_n);
    checks++;
    if (o_active_count !== 4'd2) begin errors++; $display("FAIL off_nomatch_count got %0d want 2", o_active_count); end
    send_cmd(16'hC800, low_n, ovf_n);
    send_cmd(16'h8000, low_n, ovf_n);
    send_cmd(16'hBC00, low_n, ovf_n);
    checks++;
    if (o_active_count !== 4'd3) begin errors++; $display("FAIL alloc_count got %0d want 3", o_active_count); end
    capture_frame();
    exp_t = '{7'h3C, 7'h48, 7'h43, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snap[i] !== exp_t[i]) begin errors++; $display("FAIL alloc_slot%0d got %h want %h", i, snap[i], exp_t[i]); end
    end
  endtask

  task automatic test_full();
    int ovf_tot;
    do_reset();
    for (int i = 0; i < 10; i++) send_cmd(16'h8000 | 16'((8'h30 + i) << 8), low_n, ovf_n);
    checks++;
    if (o_active_count !== 4'd10) begin errors++; $display("FAIL full_count got %0d want 10", o_active_count); end
    send_cmd(16'hD000, low_n, ovf_n);
    ovf_tot = ovf_n;
`ifdef VOICE_STEAL_EN
    checks++;
    if (ovf_n != 0) begin errors++; $display("FAIL steal_ovf got %0d want 0", ovf_n); end
    capture_frame();
    checks++;
    if (snap[0] !== 7'h50) begin errors++; $display("FAIL steal_slot0 got %h want 50", snap[0]); end
    exp_t = '{7'h50, 7'h51, 7'h32, 7'h52, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38, 7'h39};
`else
    checks++;
    if (ovf_n != 1) begin errors++; $display("FAIL full_ovf got %0d want 1", ovf_n); end
    exp_t = '{7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38, 7'h39};
`endif
    send_cmd(16'hD100, low_n, ovf_n);
    ovf_tot += ovf_n;
    send_cmd(16'hB200, low_n, ovf_n);
    checks++;
    if (ovf_n != 0) begin errors++; $display("FAIL full_rematch_ovf got %0d want 0", ovf_n); end
    send_cmd(16'hD200, low_n, ovf_n);
    ovf_tot += ovf_n;
    checks++;
`ifdef VOICE_STEAL_EN
    if (ovf_tot != 0) begin errors++; $display("FAIL steal_ovf_total got %0d want 0", ovf_tot); end
`else
    if (ovf_tot != 3) begin errors++; $display("FAIL full_ovf_total got %0d want 3", ovf_tot); end
`endif
    checks++;
    if (o_active_count !== 4'd10) begin errors++; $display("FAIL full_count_end got %0d want 10", o_active_count); end
    capture_frame();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snap[i] !== exp_t[i]) begin errors++; $display("FAIL full_slot%0d got %h want %h", i, snap[i], exp_t[i]); end
    end
  endtask

  task automatic test_stop_all();
    do_reset();
    for (int i = 0; i < 5; i++) send_cmd(16'h8000 | 16'((8'h20 + i) << 8), low_n, ovf_n);
    checks++;
    if (o_active_count !== 4'd5) begin errors++; $display("FAIL stop_pre_count got %0d want 5", o_active_count); end
    send_cmd(16'h7F00, low_n, ovf_n);
    checks++;
    if (low_n != 1) begin errors++; $display("FAIL stop_ready_low got %0d want 1", low_n); end
    checks++;
    if (o_active_count !== 4'd0) begin errors++; $display("FAIL stop_count got %0d want 0", o_active_count); end
    capture_frame();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snap[i] !== 7'h00) begin errors++; $display("FAIL stop_slot%0d got %h want 00", i, snap[i]); end
    end
  endtask

  task automatic test_clk_en_toggle();
    int strobes;
    int es;
    do_reset();
    strobes = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (c > 0) begin
        es = (strobes == 0) ? 0 : (strobes - 1) % 10;
        checks++;
        if (o_slot !== 4'(es)) begin errors++; $display("FAIL toggle_slot c=%0d got %0d want %0d", c, o_slot, es); end
        checks++;
        if (o_frame_start !== (strobes != 0 && es == 0)) begin
          errors++; $display("FAIL toggle_fs c=%0d got %b want %b", c, o_frame_start, (strobes != 0 && es == 0));
        end
      end
      clk_en = (c % 3 == 0);
      if (clk_en) strobes++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int bad;
    do_reset();
    @(negedge clk);
    clk_en = 1'b1; i_cmd = 16'hC500; i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL midscan_ready_in_reset got %b want 0", o_cmd_ready); end
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL midscan_ready_after got %b want 1", o_cmd_ready); end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midscan_ready_hold low=%0d want 0", bad); end
    checks++;
    if (o_active_count !== 4'd0) begin errors++; $display("FAIL midscan_count got %0d want 0", o_active_count); end
    capture_frame();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snap[i] !== 7'h00) begin errors++; $display("FAIL midscan_slot%0d got %h want 00", i, snap[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; i_cmd_valid = 1'b0; i_cmd = 16'h0;
    test_reset();
    test_note_on_basic();
    test_alloc_release();
    test_full();
    test_stop_all();
    test_clk_en_toggle();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter: NBANKS, 10, number of voice slots (2..15).
REQ-002 SHALL have port: clk  in  1  clock.
REQ-003 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: clk_en  in  1  pipeline advance strobe, one slot dispatched per asserted cycle.
REQ-005 SHALL have port: i_cmd_valid  in  1  command present.
REQ-006 SHALL have port: o_cmd_ready  out  1  command accepted when valid and ready are both high.
REQ-007 SHALL have port: i_cmd  in  16  [15]=1 note-on, 0 note-off; [14:8]=MIDI note; [7:0] ignored.
REQ-008 SHALL have port: o_midi  out  7  note of the dispatched slot; 0 means idle.
REQ-009 SHALL have port: o_slot  out  4  index of the dispatched slot.
REQ-010 SHALL have port: o_frame_start  out  1  high when o_slot==0 is dispatched.
REQ-011 SHALL have port: o_active_count  out  4  number of non-zero voice entries.
REQ-012 SHALL have port: o_overflow  out  1  one-cycle pulse when a note-on finds no free voice.

Function
REQ-013 SHALL hold a voice table of NBANKS 7-bit notes and NBANKS 4-bit ages (saturating at NBANKS-1).
REQ-014 SHALL implement command FSM IDLE -> SCAN -> COMMIT -> IDLE; o_cmd_ready=1 only in IDLE.
REQ-015 SHALL leave IDLE on an accepted command; STOP_ALL (note-off, note 0x7F) goes directly to COMMIT; all other commands go to SCAN.
REQ-016 SHALL in SCAN examine voice k on the k-th cycle (k=0..NBANKS-1), recording the first free index, the first index matching the note, and the lowest index of maximum age; then go to COMMIT.
REQ-017 SHALL apply all table writes at the COMMIT edge only; ready is therefore low for NBANKS+1 cycles after acceptance (1 for STOP_ALL).
REQ-018 Note-on with note 0 SHALL change nothing.
REQ-019 Note-on whose note is already in the table SHALL zero that voice's age and allocate nothing.
REQ-020 Note-on with a free voice SHALL write the note to the lowest free index with age 0, incrementing all other non-zero voices' ages (saturating).
REQ-021 Note-on with no free voice SHALL follow REQ-031.
REQ-022 Note-off SHALL clear the matching voice (note and age to 0); no match changes nothing.
REQ-023 STOP_ALL SHALL clear every voice.
REQ-024 SHALL on each clk_en cycle register o_midi<=note[idx], o_slot<=idx, o_frame_start<=(idx==0), then advance idx, wrapping NBANKS-1 -> 0; outputs hold when clk_en=0.
REQ-025 A COMMIT write to the slot dispatched in the same cycle SHALL dispatch the pre-write value.
REQ-026 o_active_count SHALL be registered, reflecting the table one cycle after COMMIT.
REQ-027 Command FSM SHALL run independently of clk_en.

Reset
REQ-028 Reset SHALL clear all notes and ages, idx=0, FSM=IDLE.
REQ-029 Reset SHALL drive o_midi=0, o_slot=0, o_frame_start=0, o_active_count=0, o_overflow=0, o_cmd_ready=0, ready=1 on the first cycle after release.
REQ-030 Reset during SCAN/COMMIT SHALL discard the in-flight command with no table write.

Configuration
REQ-031 SHALL support macro VOICE_STEAL_EN: when defined, a full note-on overwrites the oldest voice (lowest index of maximum age) with the new note at age 0, no o_overflow; when undefined, the command is dropped and o_overflow pulses for one cycle in COMMIT.

Verification
REQ-032 Note-on 0x45 after reset, clk_en=1 continuously -> ready low 11 cycles; voice 0=0x45; o_midi=0x45 when o_slot=0, count=1.
REQ-033 Note-on 0x3C, 0x40, 0x43, note-off 0x40 -> slots 0,1,2 then slot 1=0; next note-on 0x48 lands in slot 1; count=3.
REQ-034 Fill 10 voices 0x30..0x39, note-on 0x50 -> with VOICE_STEAL_EN slot 0 becomes 0x50; without it, table unchanged and o_overflow pulses once.
REQ-035 STOP_ALL (i_cmd=0x7F00) with 5 active -> ready low 1 cycle; all slots dispatch 0; count=0.
REQ-036 clk_en toggling every 3rd cycle -> o_slot steps 0..9, wraps to 0; o_frame_start only at slot 0; outputs stable between strobes.
REQ-037 Reset asserted mid-SCAN of note-on 0x45 -> table empty, no write, ready high after release.
